csi_rx_align_word: RTL and testbench
====================================

# csi_rx_align_word

Multi-lane word aligner for the CSI-2 receive path. Sits directly downstream of the per-lane byte aligners. It takes each lane's aligned byte stream and `data_vld`, de-skews the lanes into one word, and drives the byte aligners' `wait_for_sync` and `packet_done`. If SYNC does not appear on every lane within a skew window, the start is rejected as false and the byte aligners are released immediately.

## Interface
- `LANES`, default 2: number of D-PHY data lanes, 1..4.
- `MAX_SKEW`, default 2: maximum inter-lane skew tolerated, in byte-clock cycles, 1..7.

Ports:
- `clock`  in  1  byte clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  active-1 enable. When 0, all state and outputs hold.
- `data_in`  in  8*LANES  aligned bytes from the byte aligners; lane i is `[8i+7:8i]`.
- `valid_in`  in  LANES  per-lane `data_vld` from the byte aligners.
- `packet_done`  in  1  end-of-packet pulse from the packet handler.
- `wait_for_sync`  out  1  to all byte aligners.
- `align_rst`  out  1  to the byte aligners' `packet_done`; a 1-cycle pulse.
- `word_out`  out  8*LANES  de-skewed word; lane i is `[8i+7:8i]`.
- `word_vld`  out  1  `word_out` holds packet data.
- `sync_err_cnt`  out  8  count of rejected starts (see Configuration).

## Operation
- **Per-lane delay line.** Each lane has a delay line `d_i[0..MAX_SKEW]`, where `d_i[0]` is the current `data_in` lane.
- **Per-lane arrival counter.** Each lane has `cnt_i`, 3 bits, saturating at `MAX_SKEW`.
  - Cleared in IDLE.
  - Increments on each enabled cycle after that lane's `valid_in` has been seen 1 in ALIGN.
- **Skew counter.** `skew_cnt` counts enabled cycles spent in ALIGN.
- **FSM states:** IDLE, ALIGN, LOCKED, FLUSH.
- **IDLE**
  - `wait_for_sync=1`.
  - All `valid_in` bits 1: load `tap_i=0` for every lane and go to LOCKED.
  - Some, but not all, `valid_in` bits 1: go to ALIGN and mark those lanes arrived.
- **ALIGN**
  - `wait_for_sync=1`.
  - When the last lanes arrive, latch `tap_i = cnt_i` (the last lane gets 0) and go to LOCKED.
  - If `skew_cnt == MAX_SKEW` and not all lanes have arrived: timeout. Go to FLUSH and increment the error counter.
- **LOCKED**
  - `wait_for_sync=0`.
  - `word_out` lane i is registered from `d_i[tap_i]`.
  - On `packet_done=1`, or on any `valid_in` bit falling to 0: go to FLUSH.
- **FLUSH**
  - Lasts exactly 1 cycle.
  - `align_rst=1`, `wait_for_sync=1`, `valid_in` ignored.
  - Then go to IDLE.
- **Priority.** `packet_done` in ALIGN goes to FLUSH and takes priority over a timeout in the same cycle. That case does not count as an error.
- **Reset mid-operation.** Asserting `reset_n` low returns the block to IDLE immediately and asynchronously; no FLUSH pulse is issued.

## Timing
- **Reset values:**
  - `word_vld=0`, `word_out=0`, `align_rst=0`, `sync_err_cnt=0`.
  - `wait_for_sync=1`, state IDLE.
- **Header arrival.** Each byte aligner presents the packet header on `data_in` one cycle after its `valid_in` rises.
- **Latency.** Let T be the cycle in which the last lane's `valid_in` is first 1.
  - `word_vld` rises at T+2, with `word_out` holding every lane's header byte.
  - Thereafter one aligned word per enabled cycle.
- **Exit.** `word_vld` falls on the edge after `packet_done` is sampled in LOCKED. `align_rst` is high that same next cycle, since FLUSH is registered.
- **Timeout.**
  - First `valid_in` bit rises at cycle F.
  - Without full arrival, FLUSH (`align_rst=1`) occurs at cycle F+MAX_SKEW+1.
  - `word_vld` stays 0 throughout.
- **Registered outputs.** `wait_for_sync` and `align_rst` are decoded registered from state.

## Configuration
- **`CSI_RX_ALIGN_WORD_STATS_EN` defined:** `sync_err_cnt` is an 8-bit counter that increments on every ALIGN timeout. It saturates at 255 and clears only on reset.
- **Not defined:** no counter logic; `sync_err_cnt` is tied to 8'h00.

## Test plan
- **Zero skew.** LANES=2; `valid_in` goes 2'b00→2'b11 at cycle 10; headers 8'h2B/8'h2B at cycle 11 → `word_vld=1` at cycle 12 with `word_out=16'h2B2B`; subsequent bytes stay paired.
- **Max skew.** LANES=2, MAX_SKEW=2; lane0 valid at cycle 10, lane1 at cycle 12 → lane0 tap 2, lane1 tap 0. `word_vld` at cycle 14; lane0 byte from cycle 11 is paired with lane1 byte from cycle 13.
- **Timeout.** LANES=4; lanes 0–2 valid at cycle 5, lane 3 never → `align_rst` pulse at cycle 8, `word_vld` stays 0, `sync_err_cnt=1` (macro defined) or 0 (macro undefined).
- **Packet end.** LOCKED; `packet_done=1` at cycle 40 → `word_vld=0` and `align_rst=1` at cycle 41; IDLE with `wait_for_sync=1` at cycle 42. `valid_in` still 1 during cycle 41 must not re-lock.
- **Enable and reset.** `enable=0` for 3 cycles mid-packet → outputs and state frozen, then alignment resumes unchanged. Then `reset_n=0` mid-packet → `word_vld=0` and `wait_for_sync=1` immediately, with no `align_rst` pulse.

Source files
------------

// File: rtl/csi_rx_align_word.sv
// Multi-lane CSI-2 word aligner: de-skews per-lane byte streams into one word.
// Optional sync-error statistics counter enabled by CSI_RX_ALIGN_WORD_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for any lane's valid_in; byte aligners hunt for SYNC
// ALIGN  | some lanes have arrived; waiting for the rest within MAX_SKEW
// LOCKED | taps latched; one de-skewed word per enabled cycle
// FLUSH  | single-cycle align_rst pulse back to the byte aligners
module csi_rx_align_word #(
    parameter int LANES    = 2,
    parameter int MAX_SKEW = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [8*LANES-1:0] data_in,
    input  logic [LANES-1:0]   valid_in,
    input  logic               packet_done,
    output logic               wait_for_sync,
    output logic               align_rst,
    output logic [8*LANES-1:0] word_out,
    output logic               word_vld,
    output logic [7:0]         sync_err_cnt
);

    localparam logic [2:0] SKEW_LIM = 3'(MAX_SKEW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t             state;
    logic [LANES-1:0]   arrived;
    logic [LANES-1:0]   seen;
    logic [2:0]         cnt [LANES];
    logic [2:0]         tap [LANES];
    logic [2:0]         skew_cnt;
    logic [7:0]         dly [LANES][MAX_SKEW];
    logic [8*LANES-1:0] tapped;
    logic               timeout;

    assign seen    = arrived | valid_in;
    assign timeout = enable && (state == ALIGN) && !packet_done
                     && !(&seen) && (skew_cnt == SKEW_LIM);

    // dly[i][k] holds lane i's byte from k+1 enabled cycles ago; tap 0 is the live byte
    always_comb begin
        tapped = '0;
        for (int i = 0; i < LANES; i++) begin
            tapped[8*i +: 8] = data_in[8*i +: 8];
            for (int k = 0; k < MAX_SKEW; k++) begin
                if (tap[i] == 3'(k + 1)) begin
                    tapped[8*i +: 8] = dly[i][k];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            arrived       <= '0;
            skew_cnt      <= '0;
            word_out      <= '0;
            word_vld      <= 1'b0;
            align_rst     <= 1'b0;
            wait_for_sync <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                cnt[i] <= '0;
                tap[i] <= '0;
                for (int k = 0; k < MAX_SKEW; k++) begin
                    dly[i][k] <= '0;
                end
            end
        end else if (enable) begin
            for (int i = 0; i < LANES; i++) begin
                dly[i][0] <= data_in[8*i +: 8];
                for (int k = 1; k < MAX_SKEW; k++) begin
                    dly[i][k] <= dly[i][k-1];
                end
            end
            align_rst     <= 1'b0;
            word_vld      <= 1'b0;
            wait_for_sync <= 1'b1;

            case (state)
                IDLE: begin
                    arrived  <= valid_in;
                    skew_cnt <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        cnt[i] <= {2'b00, valid_in[i]};
                    end
                    if (&valid_in) begin
                        for (int i = 0; i < LANES; i++) begin
                            tap[i] <= '0;
                        end
                        state         <= LOCKED;
                        wait_for_sync <= 1'b0;
                    end else if (|valid_in) begin
                        skew_cnt <= 3'd1;
                        state    <= ALIGN;
                    end
                end

                ALIGN: begin
                    arrived <= seen;
                    if (skew_cnt != SKEW_LIM) begin
                        skew_cnt <= skew_cnt + 3'd1;
                    end
                    // cnt counts cycles since the lane's first valid, so it is the tap it needs
                    for (int i = 0; i < LANES; i++) begin
                        if (seen[i] && cnt[i] != SKEW_LIM) begin
                            cnt[i] <= cnt[i] + 3'd1;
                        end
                    end
                    if (packet_done) begin
                        state     <= FLUSH;
                        align_rst <= 1'b1;
                    end else if (&seen) begin
                        for (int i = 0; i < LANES; i++) begin
                            tap[i] <= cnt[i];
                        end
                        state         <= LOCKED;
                        wait_for_sync <= 1'b0;
                    end else if (timeout) begin
                        state     <= FLUSH;
                        align_rst <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (packet_done || !(&valid_in)) begin
                        state     <= FLUSH;
                        align_rst <= 1'b1;
                    end else begin
                        word_out      <= tapped;
                        word_vld      <= 1'b1;
                        wait_for_sync <= 1'b0;
                    end
                end

                FLUSH: begin
                    state    <= IDLE;
                    arrived  <= '0;
                    skew_cnt <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        cnt[i] <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSI_RX_ALIGN_WORD_STATS_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (timeout && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign sync_err_cnt = err_cnt;
`else
    assign sync_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_csi_rx_align_word.sv
// Testbench for csi_rx_align_word: directed vector table, hand-written corner
// sequences, and randomized packets checked against a timestamp-based model.
module tb_csi_rx_align_word;

    localparam int LANES    = 4;
    localparam int MAX_SKEW = 2;

`ifdef CSI_RX_ALIGN_WORD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [7:0] E1 = STATS ? 8'd1 : 8'd0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  valid_in = '0;
    logic        packet_done = 1'b0;
    logic        wait_for_sync;
    logic        align_rst;
    logic [31:0] word_out;
    logic        word_vld;
    logic [7:0]  sync_err_cnt;

    csi_rx_align_word #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .packet_done   (packet_done),
        .wait_for_sync (wait_for_sync),
        .align_rst     (align_rst),
        .word_out      (word_out),
        .word_vld      (word_vld),
        .sync_err_cnt  (sync_err_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [3:0] v, input logic [31:0] d, input logic pd);
        enable      = en;
        valid_in    = v;
        data_in     = d;
        packet_done = pd;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        pd;
        logic        vld;
        logic [31:0] word;
        logic        ws;
        logic        ar;
        logic [7:0]  err;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic [3:0] v, input logic [31:0] d, input logic pd,
                       input logic vld, input logic [31:0] word, input logic ws,
                       input logic ar, input logic [7:0] err);
        vec_t r;
        r.v = v; r.d = d; r.pd = pd; r.vld = vld; r.word = word;
        r.ws = ws; r.ar = ar; r.err = err;
        tbl.push_back(r);
    endtask

    // Reference model: tracks each lane's first-valid timestamp and replays history
    localparam int M_IDLE = 0, M_ALIGN = 1, M_LOCK = 2, M_FLUSH = 3;
    int          m_mode, m_n, m_start, m_err;
    int          m_first [LANES];
    int          m_tap [LANES];
    logic [31:0] m_hist [16];
    logic        m_vld, m_ws, m_ar;
    logic [31:0] m_word;

    task automatic model_reset();
        m_mode = M_IDLE; m_n = 0; m_start = 0; m_err = 0;
        m_vld = 1'b0; m_ws = 1'b1; m_ar = 1'b0; m_word = '0;
        for (int i = 0; i < LANES; i++) begin
            m_first[i] = -1;
            m_tap[i] = 0;
        end
        for (int k = 0; k < 16; k++) m_hist[k] = '0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic pd);
        bit all_in;
        m_n++;
        m_hist[m_n & 15] = d;
        m_vld = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (v == 4'hF) begin
                    for (int i = 0; i < LANES; i++) m_tap[i] = 0;
                    m_mode = M_LOCK;
                end else if (v != 4'h0) begin
                    m_start = m_n;
                    for (int i = 0; i < LANES; i++) m_first[i] = v[i] ? m_n : -1;
                    m_mode = M_ALIGN;
                end
            end
            M_ALIGN: begin
                all_in = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (v[i] && m_first[i] < 0) m_first[i] = m_n;
                    if (m_first[i] < 0) all_in = 1'b0;
                end
                if (pd) begin
                    m_mode = M_FLUSH;
                end else if (all_in) begin
                    for (int i = 0; i < LANES; i++) m_tap[i] = m_n - m_first[i];
                    m_mode = M_LOCK;
                end else if (m_n - m_start == MAX_SKEW) begin
                    m_mode = M_FLUSH;
                    if (STATS && m_err < 255) m_err++;
                end
            end
            M_LOCK: begin
                if (pd || v != 4'hF) begin
                    m_mode = M_FLUSH;
                end else begin
                    m_vld = 1'b1;
                    for (int i = 0; i < LANES; i++)
                        m_word[8*i +: 8] = m_hist[(m_n - m_tap[i]) & 15][8*i +: 8];
                end
            end
            default: begin
                m_mode = M_IDLE;
                for (int i = 0; i < LANES; i++) m_first[i] = -1;
            end
        endcase
        m_ws = (m_mode != M_LOCK);
        m_ar = (m_mode == M_FLUSH);
    endtask

    task automatic rcyc(input logic [3:0] v, input logic pd);
        logic        en;
        logic [31:0] d;
        en = ($urandom_range(0, 7) != 0);
        d  = $urandom;
        cyc(en, v, d, pd);
        if (en) model_step(v, d, pd);
        chk("rnd_vld", {31'd0, word_vld}, {31'd0, m_vld});
        chk("rnd_ws", {31'd0, wait_for_sync}, {31'd0, m_ws});
        chk("rnd_ar", {31'd0, align_rst}, {31'd0, m_ar});
        chk("rnd_err", {24'd0, sync_err_cnt}, 32'(m_err));
        if (m_vld) chk("rnd_word", word_out, m_word);
    endtask

    int         s [LANES];
    int         gap, body, mx;
    logic [3:0] vv;
    logic       pdv;

    initial begin
        // v, d, pd | vld, word, ws, ar, err (outputs after the edge)
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b1111, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0);
        row(4'b1111, 32'h2B2B2B2B, 1'b0, 1'b1, 32'h2B2B2B2B, 1'b0, 1'b0, 8'd0);
        row(4'b1111, 32'h11223344, 1'b0, 1'b1, 32'h11223344, 1'b0, 1'b0, 8'd0);
        row(4'b1111, 32'h55667788, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 8'd0);
        row(4'b1111, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0001, 32'h000000A0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b1111, 32'h000000A1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0);
        row(4'b1111, 32'hB3B2B1A2, 1'b0, 1'b1, 32'hB3B2B1A0, 1'b0, 1'b0, 8'd0);
        row(4'b1111, 32'hC3C2C1A3, 1'b0, 1'b1, 32'hC3C2C1A1, 1'b0, 1'b0, 8'd0);
        row(4'b0111, 32'hD3D2D1A4, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 8'd0);
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0111, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0111, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'd0);
        row(4'b0111, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, E1);
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);
        row(4'b0001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);
        row(4'b0001, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);
        row(4'b0001, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, E1);
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);
        row(4'b0011, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);
        row(4'b1111, 32'h00002120, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, E1);
        row(4'b1111, 32'h43423130, 1'b0, 1'b1, 32'h43422120, 1'b0, 1'b0, E1);
        row(4'b1111, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, E1);
        row(4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, E1);

        repeat (3) @(posedge clock);
        #1;
        chk("rst_vld", {31'd0, word_vld}, 32'd0);
        chk("rst_word", word_out, 32'd0);
        chk("rst_ar", {31'd0, align_rst}, 32'd0);
        chk("rst_ws", {31'd0, wait_for_sync}, 32'd1);
        chk("rst_err", {24'd0, sync_err_cnt}, 32'd0);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(1'b1, tbl[k].v, tbl[k].d, tbl[k].pd);
            chk($sformatf("tbl%0d_vld", k), {31'd0, word_vld}, {31'd0, tbl[k].vld});
            chk($sformatf("tbl%0d_ws", k), {31'd0, wait_for_sync}, {31'd0, tbl[k].ws});
            chk($sformatf("tbl%0d_ar", k), {31'd0, align_rst}, {31'd0, tbl[k].ar});
            chk($sformatf("tbl%0d_err", k), {24'd0, sync_err_cnt}, {24'd0, tbl[k].err});
            if (tbl[k].vld) chk($sformatf("tbl%0d_word", k), word_out, tbl[k].word);
        end

        // enable freeze mid-packet with lane 0 two cycles early
        cyc(1'b1, 4'b0001, 32'h0, 1'b0);
        chk("frz_align_ws", {31'd0, wait_for_sync}, 32'd1);
        cyc(1'b1, 4'b0001, 32'h00000010, 1'b0);
        cyc(1'b1, 4'b1111, 32'h00000011, 1'b0);
        chk("frz_lock_ws", {31'd0, wait_for_sync}, 32'd0);
        cyc(1'b1, 4'b1111, 32'h23222112, 1'b0);
        chk("frz_w0", word_out, 32'h23222110);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b0000, 32'hFFFFFFFF, 1'b1);
            chk("frz_hold_vld", {31'd0, word_vld}, 32'd1);
            chk("frz_hold_word", word_out, 32'h23222110);
            chk("frz_hold_ws", {31'd0, wait_for_sync}, 32'd0);
            chk("frz_hold_ar", {31'd0, align_rst}, 32'd0);
        end
        cyc(1'b1, 4'b1111, 32'h33323113, 1'b0);
        chk("frz_w1", word_out, 32'h33323111);
        cyc(1'b1, 4'b1111, 32'h43424114, 1'b0);
        chk("frz_w2", word_out, 32'h43424112);
        chk("frz_w2_vld", {31'd0, word_vld}, 32'd1);

        // asynchronous reset mid-packet
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vld", {31'd0, word_vld}, 32'd0);
        chk("arst_ws", {31'd0, wait_for_sync}, 32'd1);
        chk("arst_ar", {31'd0, align_rst}, 32'd0);
        @(posedge clock);
        #1;
        chk("arst_ar_hold", {31'd0, align_rst}, 32'd0);
        reset_n = 1'b1;
        model_reset();
        cyc(1'b1, 4'b1111, 32'h0, 1'b0);
        chk("arst_relock_ws", {31'd0, wait_for_sync}, 32'd0);
        model_step(4'b1111, 32'h0, 1'b0);

        for (int p = 0; p < 80; p++) begin
            gap  = $urandom_range(1, 3);
            body = $urandom_range(2, 8);
            mx   = 0;
            for (int i = 0; i < LANES; i++) s[i] = $urandom_range(0, MAX_SKEW);
            if ($urandom_range(0, 4) == 0) s[$urandom_range(0, LANES - 1)] = MAX_SKEW + 2;
            for (int i = 0; i < LANES; i++) if (s[i] > mx) mx = s[i];
            for (int g = 0; g < gap; g++) rcyc(4'b0000, 1'b0);
            for (int c = 0; c < mx + body; c++) begin
                for (int i = 0; i < LANES; i++) vv[i] = (c >= s[i]);
                pdv = ((c == mx + body - 1) && ($urandom_range(0, 1) == 1))
                      || ($urandom_range(0, 24) == 0);
                rcyc(vv, pdv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
